// File: rtl/b2b_pkg.sv
// Shared definitions for the board-to-board event merger.
//   DATA_WIDTH     : default word width; the top bit is the metadata flag
//   HDR_MARKER     : tag field (bits[63:56]) of a header word
//   FTR_MARKER     : tag field of a footer word
//   SYNTH_FOOTER   : footer written to close a truncated event
//   state_t        : merger FSM states
//   is_header/is_footer : word classification from metadata flag and tag field
package b2b_pkg;

    localparam int DATA_WIDTH = 65;
    localparam logic [7:0] HDR_MARKER = 8'hAB;
    localparam logic [7:0] FTR_MARKER = 8'hCD;
    localparam logic [DATA_WIDTH-1:0] SYNTH_FOOTER = {1'b1, FTR_MARKER, 56'h0};

    typedef enum logic {
        ST_ARB = 1'b0,
        ST_FWD = 1'b1
    } state_t;

    // The marker is passed in so the top level can use its own parameters.
    function automatic logic is_header(input logic meta, input logic [7:0] tag,
                                       input logic [7:0] marker);
        return meta && (tag == marker);
    endfunction

    function automatic logic is_footer(input logic meta, input logic [7:0] tag,
                                       input logic [7:0] marker);
        return meta && (tag == marker);
    endfunction

endpackage

// File: rtl/b2b_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector, one bit per input
//   ptr       : index of the highest-priority input this cycle (must be < N)
//   gnt       : one-hot grant (zero when nothing requests)
//   gnt_idx   : index of the granted input
//   gnt_valid : at least one request present
module b2b_rr_arbiter #(
    parameter int N     = 14,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    // cand_idx[gi] is the input that sits gi places after the pointer.
    logic [IDX_W-1:0] cand_idx [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum = {1'b0, ptr} + (IDX_W+1)'(gi);
            assign cand_idx[gi] = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N))
                                                         : sum[IDX_W-1:0];
        end
    endgenerate

    // Scan from the far end back toward the pointer so the closest requester wins.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[cand_idx[i]]) begin
                gnt_idx   = cand_idx[i];
                gnt_valid = 1'b1;
            end
        end
        gnt = gnt_valid ? (N'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/b2b_event_merger.sv
// Merges whole events from N show-ahead input FIFOs into one output FIFO.
// Round-robin between inputs, events never interleaved, malformed framing
// discarded and counted, truncated events closed with a synthetic footer.
//   clock, reset        : clock, synchronous active-high reset
//   in_data/in_empty    : head word and empty flag of each input FIFO
//   in_rd_en            : pop strobe per input (one-hot or zero, combinational)
//   out_data/out_wren   : registered write port of the output FIFO
//   out_almost_full     : output FIFO has at most 2 free slots left
//   event_count         : events written (wrapping)
//   error_count         : framing errors (saturating)
//   busy                : an event is being forwarded
module b2b_event_merger #(
    parameter int         DATA_WIDTH         = 65,
    parameter int         TOTAL_INPUT_BOARDS = 14,
    parameter int         CNT_WIDTH          = 32,
    parameter logic [7:0] HDR_MARKER         = 8'hAB,
    parameter logic [7:0] FTR_MARKER         = 8'hCD
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data  [TOTAL_INPUT_BOARDS],
    input  logic                  in_empty [TOTAL_INPUT_BOARDS],
    output logic                  in_rd_en [TOTAL_INPUT_BOARDS],
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_wren,
    input  logic                  out_almost_full,
    output logic [CNT_WIDTH-1:0]  event_count,
    output logic [15:0]           error_count,
    output logic                  busy
);
    import b2b_pkg::*;

    localparam int N     = TOTAL_INPUT_BOARDS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [DATA_WIDTH-1:0] SYNTH_WORD = {1'b1, FTR_MARKER, {(DATA_WIDTH-9){1'b0}}};

    state_t                state_reg, state_next;
    logic [IDX_W-1:0]      ptr_reg, ptr_next;
    logic [IDX_W-1:0]      grant_reg, grant_next;
    logic                  first_reg, first_next;    // next pop in FWD is the event's own header
    logic [DATA_WIDTH-1:0] out_data_reg, out_data_next;
    logic                  out_wren_reg, out_wren_next;
    logic [CNT_WIDTH-1:0]  event_count_reg, event_count_next;
    logic [15:0]           error_count_reg, error_count_next;

    logic [N-1:0]          req_vec;
    logic [N-1:0]          rd_vec;
    logic [N-1:0]          arb_gnt;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_valid;
    logic [DATA_WIDTH-1:0] arb_head;
    logic [DATA_WIDTH-1:0] fwd_head;
    logic [IDX_W-1:0]      grant_inc;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_port
            assign req_vec[gi]  = ~in_empty[gi];
            assign in_rd_en[gi] = rd_vec[gi];
        end
    endgenerate

    b2b_rr_arbiter #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (req_vec),
        .ptr       (ptr_reg),
        .gnt       (arb_gnt),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    assign arb_head  = in_data[arb_idx];
    assign fwd_head  = in_data[grant_reg];
    assign grant_inc = (grant_reg == IDX_W'(N - 1)) ? '0 : grant_reg + 1'b1;

    always_comb begin
        state_next       = state_reg;
        ptr_next         = ptr_reg;
        grant_next       = grant_reg;
        first_next       = first_reg;
        out_data_next    = out_data_reg;
        out_wren_next    = 1'b0;
        event_count_next = event_count_reg;
        error_count_next = error_count_reg;
        rd_vec           = '0;

        case (state_reg)
            ST_ARB: begin
                if (arb_valid) begin
                    grant_next = arb_idx;
                    if (is_header(arb_head[DATA_WIDTH-1], arb_head[DATA_WIDTH-2 -: 8], HDR_MARKER)) begin
                        // Header stays in the FIFO; it is popped by the first FWD cycle.
                        state_next = ST_FWD;
                        first_next = 1'b1;
                    end else begin
                        rd_vec = arb_gnt;
                        if (error_count_reg != 16'hFFFF)
                            error_count_next = error_count_reg + 16'd1;
                    end
                end
            end
            ST_FWD: begin
                if (!in_empty[grant_reg] && !out_almost_full) begin
                    if (!first_reg &&
                        is_header(fwd_head[DATA_WIDTH-1], fwd_head[DATA_WIDTH-2 -: 8], HDR_MARKER)) begin
                        // A new event started before this one ended: close it here
                        // and leave the new header for the next arbitration.
                        out_data_next    = SYNTH_WORD;
                        out_wren_next    = 1'b1;
                        event_count_next = event_count_reg + CNT_WIDTH'(1);
                        if (error_count_reg != 16'hFFFF)
                            error_count_next = error_count_reg + 16'd1;
                        ptr_next   = grant_inc;
                        state_next = ST_ARB;
                    end else begin
                        rd_vec[grant_reg] = 1'b1;
                        out_data_next     = fwd_head;
                        out_wren_next     = 1'b1;
                        first_next        = 1'b0;
                        if (is_footer(fwd_head[DATA_WIDTH-1], fwd_head[DATA_WIDTH-2 -: 8], FTR_MARKER)) begin
                            event_count_next = event_count_reg + CNT_WIDTH'(1);
                            ptr_next         = grant_inc;
                            state_next       = ST_ARB;
                        end
                    end
                end
            end
            default: state_next = ST_ARB;
        endcase

        // Never pop while reset is held: the partial event is being abandoned.
        if (reset)
            rd_vec = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= ST_ARB;
            ptr_reg         <= '0;
            grant_reg       <= '0;
            first_reg       <= 1'b0;
            out_data_reg    <= '0;
            out_wren_reg    <= 1'b0;
            event_count_reg <= '0;
            error_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            ptr_reg         <= ptr_next;
            grant_reg       <= grant_next;
            first_reg       <= first_next;
            out_data_reg    <= out_data_next;
            out_wren_reg    <= out_wren_next;
            event_count_reg <= event_count_next;
            error_count_reg <= error_count_next;
        end
    end

    assign out_data    = out_data_reg;
    assign out_wren    = out_wren_reg;
    assign event_count = event_count_reg;
    assign error_count = error_count_reg;
    assign busy        = (state_reg == ST_FWD);

endmodule

// File: tb/tb_b2b_event_merger.sv
// Directed bench for b2b_event_merger: input FIFOs are modelled as queues,
// every output word is logged with its cycle number and compared against
// hand-written expected sequences.
module tb_b2b_event_merger;

    localparam int N  = 14;
    localparam int DW = 65;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data  [N];
    logic          in_empty [N];
    logic          in_rd_en [N];
    logic [DW-1:0] out_data;
    logic          out_wren;
    logic          out_almost_full;
    logic [31:0]   event_count;
    logic [15:0]   error_count;
    logic          busy;

    logic [DW-1:0] fifo_q [N][$];
    logic [DW-1:0] out_log [$];
    int            out_cyc [$];
    logic [DW-1:0] exp_q [$];
    int            cycle_no = 0;
    int            pop_total = 0;
    int            pop_viol = 0;
    int            checks = 0;
    int            errors = 0;

    always #5 clock = ~clock;

    b2b_event_merger dut (
        .clock           (clock),
        .reset           (reset),
        .in_data         (in_data),
        .in_empty        (in_empty),
        .in_rd_en        (in_rd_en),
        .out_data        (out_data),
        .out_wren        (out_wren),
        .out_almost_full (out_almost_full),
        .event_count     (event_count),
        .error_count     (error_count),
        .busy            (busy)
    );

    function automatic logic [DW-1:0] hw(input logic [55:0] p);
        return {1'b1, 8'hAB, p};
    endfunction
    function automatic logic [DW-1:0] fw(input logic [55:0] p);
        return {1'b1, 8'hCD, p};
    endfunction
    function automatic logic [DW-1:0] bw(input logic [55:0] p);
        return {1'b0, 8'h12, p};
    endfunction
    // Metadata word with a foreign marker: treated as a body word.
    function automatic logic [DW-1:0] mw(input logic [55:0] p);
        return {1'b1, 8'h77, p};
    endfunction

    localparam logic [DW-1:0] SYNTH = {1'b1, 8'hCD, 56'h0};

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (fifo_q[i].size() > 0) begin
                in_data[i]  = fifo_q[i][0];
                in_empty[i] = 1'b0;
            end else begin
                in_data[i]  = '0;
                in_empty[i] = 1'b1;
            end
        end
    endtask

    task automatic push(input int ch, input logic [DW-1:0] w);
        fifo_q[ch].push_back(w);
        drive_inputs();
    endtask

    // One clock: sample at the falling edge, apply pops just after the rising edge.
    task automatic step();
        logic [N-1:0] pops;
        int npop;
        @(negedge clock);
        npop = 0;
        for (int i = 0; i < N; i++) begin
            pops[i] = in_rd_en[i];
            if (in_rd_en[i]) begin
                npop++;
                if (fifo_q[i].size() == 0) pop_viol++;
            end
        end
        if (npop > 1) pop_viol++;
        pop_total += npop;
        if (out_wren) begin
            out_log.push_back(out_data);
            out_cyc.push_back(cycle_no);
            $display("cyc=%0d write data=%h ev=%0d err=%0d", cycle_no, out_data, event_count, error_count);
        end
        @(posedge clock);
        #1;
        cycle_no++;
        for (int i = 0; i < N; i++)
            if (pops[i] && fifo_q[i].size() > 0) void'(fifo_q[i].pop_front());
        drive_inputs();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_log();
        out_log.delete();
        out_cyc.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < N; i++) fifo_q[i].delete();
        drive_inputs();
        step();
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_len"}, 128'(out_log.size()), 128'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++)
            if (k < out_log.size())
                chk($sformatf("%s_w%0d", tag, k), 128'(out_log[k]), 128'(exp_q[k]));
    endtask

    initial begin
        int log_at_stall;
        int pops_at_stall;
        int any_rd;

        reset = 1'b1;
        out_almost_full = 1'b0;
        drive_inputs();
        step();

        // Reset values
        do_reset();
        any_rd = 0;
        for (int i = 0; i < N; i++) any_rd += int'(in_rd_en[i]);
        chk("rst_wren", out_wren, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ev", event_count, 0);
        chk("rst_err", error_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rden", any_rd, 0);
        reset = 1'b0;

        // T1: single event on input 3, streamed on consecutive cycles
        clear_log();
        push(3, hw(56'h1)); push(3, bw(56'h2)); push(3, mw(56'h3)); push(3, fw(56'h4));
        chk("t1_busy_arb", busy, 0);
        step();
        chk("t1_busy_fwd", busy, 1);
        run(10);
        exp_q = '{hw(56'h1), bw(56'h2), mw(56'h3), fw(56'h4)};
        check_log("t1");
        if (out_cyc.size() == 4)
            chk("t1_consec", out_cyc[3] - out_cyc[0], 3);
        chk("t1_ev", event_count, 1);
        chk("t1_err", error_count, 0);
        chk("t1_busy_end", busy, 0);

        // T2: inputs 0 and 5 together; input 0 first, one idle cycle between
        do_reset(); reset = 1'b0;
        clear_log();
        push(0, hw(56'h10)); push(0, bw(56'h11)); push(0, fw(56'h12));
        push(5, hw(56'h20)); push(5, bw(56'h21)); push(5, fw(56'h22));
        run(16);
        exp_q = '{hw(56'h10), bw(56'h11), fw(56'h12), hw(56'h20), bw(56'h21), fw(56'h22)};
        check_log("t2");
        if (out_cyc.size() == 6) begin
            chk("t2_gap01", out_cyc[1] - out_cyc[0], 1);
            chk("t2_gap23", out_cyc[3] - out_cyc[2], 2);
            chk("t2_gap45", out_cyc[5] - out_cyc[4], 1);
        end
        chk("t2_ev", event_count, 2);

        // Pointer now 6: input 7 must beat input 0
        clear_log();
        push(0, hw(56'h30)); push(0, fw(56'h31));
        push(7, hw(56'h40)); push(7, fw(56'h41));
        run(12);
        exp_q = '{hw(56'h40), fw(56'h41), hw(56'h30), fw(56'h31)};
        check_log("t2_ptr6");

        // Pointer now 1: order 12, 13, then wrap to 0
        clear_log();
        push(0, hw(56'h50)); push(0, fw(56'h51));
        push(12, hw(56'h60)); push(12, fw(56'h61));
        push(13, hw(56'h70)); push(13, fw(56'h71));
        run(16);
        exp_q = '{hw(56'h60), fw(56'h61), hw(56'h70), fw(56'h71), hw(56'h50), fw(56'h51)};
        check_log("t2_wrap");
        chk("t2_ev_end", event_count, 7);

        // T3: two stray words ahead of the header are discarded
        do_reset(); reset = 1'b0;
        clear_log();
        push(2, bw(56'h1)); push(2, mw(56'h2)); push(2, hw(56'h3)); push(2, fw(56'h4));
        step();
        chk("t3_err_first", error_count, 1);
        run(10);
        exp_q = '{hw(56'h3), fw(56'h4)};
        check_log("t3");
        chk("t3_err", error_count, 2);
        chk("t3_ev", event_count, 1);

        // T4: header inside an event forces a synthetic footer
        do_reset(); reset = 1'b0;
        clear_log();
        push(1, hw(56'h1)); push(1, bw(56'h2)); push(1, hw(56'h3)); push(1, fw(56'h4));
        run(14);
        exp_q = '{hw(56'h1), bw(56'h2), SYNTH, hw(56'h3), fw(56'h4)};
        check_log("t4");
        chk("t4_ev", event_count, 2);
        chk("t4_err", error_count, 1);

        // T5: almost-full stall for 10 cycles mid-event
        do_reset(); reset = 1'b0;
        clear_log();
        push(4, hw(56'h1));
        for (int k = 2; k <= 7; k++) push(4, bw(56'(k)));
        push(4, fw(56'h8));
        run(3);
        out_almost_full = 1'b1;
        pops_at_stall = pop_total;
        step();
        log_at_stall = out_log.size();
        run(9);
        chk("t5_stall_pops", pop_total - pops_at_stall, 0);
        chk("t5_stall_writes", out_log.size() - log_at_stall, 0);
        chk("t5_stall_busy", busy, 1);
        out_almost_full = 1'b0;
        run(12);
        exp_q = '{hw(56'h1), bw(56'h2), bw(56'h3), bw(56'h4), bw(56'h5), bw(56'h6), bw(56'h7), fw(56'h8)};
        check_log("t5");
        chk("t5_ev", event_count, 1);

        // T6: reset in the middle of an event
        do_reset(); reset = 1'b0;
        clear_log();
        push(5, hw(56'h1)); push(5, bw(56'h2)); push(5, bw(56'h3)); push(5, bw(56'h4)); push(5, fw(56'h5));
        run(3);
        chk("t6_busy_mid", busy, 1);
        do_reset();
        chk("t6_rst_wren", out_wren, 0);
        chk("t6_rst_data", out_data, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ev", event_count, 0);
        reset = 1'b0;
        clear_log();
        push(5, hw(56'h9)); push(5, fw(56'hA));
        run(8);
        exp_q = '{hw(56'h9), fw(56'hA)};
        check_log("t6");
        chk("t6_ev", event_count, 1);
        chk("t6_err", error_count, 0);

        chk("pop_onehot", pop_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/b2b_event_merger.md
# b2b_event_merger

Receive-side counterpart of the board-to-board switch. On the destination board, one input FIFO per source board holds whole events routed here by the remote switches. This block arbitrates round-robin between those FIFOs and forwards complete events, never interleaved, into one output FIFO that feeds downstream track processing. It also detects malformed event framing and counts forwarded events and framing errors.

## Interface
Parameters:
- `DATA_WIDTH`, 65: word width, bit 64 = metadata flag.
- `TOTAL_INPUT_BOARDS`, 14: number of source-board input FIFOs (N).
- `CNT_WIDTH`, 32: event counter width.
- `HDR_MARKER`, 8'hAB: bits[63:56] of a header word.
- `FTR_MARKER`, 8'hCD: bits[63:56] of a footer word.

Ports:
- `clock`  in  1  main TP clock, nominally 200 MHz.
- `reset`  in  1  reset; synchronous and active-high.
- `in_data [N]`  in  DATA_WIDTH  head word of each input FIFO; show-ahead, valid while `in_empty` is low.
- `in_empty [N]`  in  1  input FIFO empty.
- `in_rd_en [N]`  out  1  pops the head word of the input FIFO.
- `out_data`  out  DATA_WIDTH  word written to the output FIFO.
- `out_wren`  out  1  output FIFO write enable.
- `out_almost_full`  in  1  output FIFO almost full; asserts with at least 2 free slots.
- `event_count`  out  CNT_WIDTH  events written, including truncated events; wraps.
- `error_count`  out  16  framing errors; saturates at 16'hFFFF.
- `busy`  out  1  high while in FWD.

## Operation
- Header word: bit64 = 1 and bits[63:56] = HDR_MARKER.
- Footer word: bit64 = 1 and bits[63:56] = FTR_MARKER.
- Any other word is a body word. This includes metadata words with other markers.
- The FSM has two states: ARB and FWD. Reset value is ARB with round-robin pointer 0.
- **ARB:**
  - Scan inputs starting at the pointer and select the first input with `in_empty` = 0. Register it as `grant`.
  - If its head is a header: go to FWD. The header is not popped in ARB.
  - If its head is not a header: pop it, discard it, increment `error_count`, and stay in ARB.
  - If no input is non-empty: stay in ARB.
- **FWD:** each cycle with `!in_empty[grant] && !out_almost_full`:
  - Pop the head word and write it out.
  - If the word is a footer: increment `event_count`, set pointer = grant+1 (mod N), and go to ARB.
- **Truncated event:** a header appears at the head while in FWD, other than the event's own first word.
  - Do not pop it.
  - Write the synthetic footer {1'b1, FTR_MARKER, 56'h0}.
  - Increment both counters, advance the pointer, and go to ARB.
- **Stall:** when `out_almost_full` = 1 or the granted input is empty, there is no pop and no write. The state is held, and the event stays locked to `grant`.
- `in_rd_en` is one-hot or zero. It is driven only for `grant` in FWD, or for the discarded input in ARB.

## Timing
- `in_rd_en` is combinational from state, `grant`, `in_empty`, `in_data[grant]` and `out_almost_full`.
- `out_data` and `out_wren` are registered: a word popped in cycle t is written in cycle t+1.
- The almost-full slack of 2 absorbs this one-cycle pipeline.
- ARB costs exactly 1 cycle per event. With all inputs full, the gap between events is 1 idle cycle, and body words stream at 1 word/cycle.
- Reset values: `in_rd_en` = 0, `out_wren` = 0, `out_data` = 0, `event_count` = 0, `error_count` = 0, `busy` = 0. These take effect the cycle after `reset` is sampled high.
- Reset mid-event abandons the partial event without a synthetic footer, because downstream FIFOs share the same reset.
- The pointer wraps from N-1 to 0.
- `event_count` wraps at 2^CNT_WIDTH.
- Simultaneous footer completion and a new header on another input: the new event is granted in the following ARB cycle.

## Structure
- Shared package `b2b_pkg`:
  - `DATA_WIDTH`
  - `HDR_MARKER` and `FTR_MARKER`
  - `is_header()` and `is_footer()` functions
  - synthetic-footer constant
  - FSM enum
- Sub-module `b2b_rr_arbiter`: N-bit request vector plus pointer in, one-hot grant and index out; combinational priority rotate.
- The top level instantiates the arbiter and holds the FSM, the output register and the counters.

## Test plan
- Input 3 holds H, B0, B1, F; others empty -> `out_data` H, B0, B1, F on 4 consecutive cycles; `event_count` = 1; `error_count` = 0.
- Inputs 0 and 5 each hold a 3-word event at once -> input 0's event completes first, then 1 idle cycle, then input 5's event; no interleaving; pointer ends at 6.
- Input 2 holds B, B, H, F -> two pops discarded; `error_count` = 2; then H, F forwarded.
- Input 1 holds H, B, H, F -> output H, B, {1,CD,0}, then after ARB: H, F; `event_count` = 2; `error_count` = 1.
- `out_almost_full` held high for 10 cycles mid-event -> no `in_rd_en`, no `out_wren`; the event resumes without loss or duplication.
- `reset` asserted mid-event -> next cycle all outputs and counters are 0 and the FSM is in ARB; the next event is forwarded normally.
